imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time loader upstream of the MIPS core. Accepts a stream of 32-bit instruction words and writes each one little-endian into the byte-wide instruction memory at consecutive addresses from 0.
- Holds the core in a not-running state until the final word is written, then raises cpu_run.
- Gives a synthesizable replacement for loading the program by direct hierarchical memory writes.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; must be a multiple of 4.
- ADDR_W, 32, width of im_addr and word_count.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- word_valid  in  1  upstream presents a valid instruction word.
- word_data  in  32  instruction word; bits [7:0] go to the lowest byte address.
- word_last  in  1  qualifies word_data as the final word of the program.
- word_ready  out  1  loader accepts a word this cycle.
- reload  in  1  single-cycle pulse; restarts loading from address 0.
- im_we  out  1  instruction memory byte write enable.
- im_addr  out  ADDR_W  byte address of the current write.
- im_wdata  out  8  byte being written.
- cpu_run  out  1  core is released and may fetch.
- load_err  out  1  sticky flag: program exceeded MEM_BYTES.
- word_count  out  ADDR_W  number of words written since the last reset or reload.

Behaviour:
- States: IDLE, WRITE, DONE, ERROR.
- Reset: async on rst_n=0. State goes to IDLE. All of the following clear to 0: word_ready, im_we, im_addr, im_wdata, cpu_run, load_err, word_count, the internal base address and the byte index.
  - word_ready is 0 while rst_n is low and returns to 1 on the first clock after release.
- IDLE:
  - word_ready=1 and im_we=0.
  - A handshake is word_valid & word_ready. On a handshake the loader latches word_data and word_last.
  - If base+4 <= MEM_BYTES, go to WRITE with byte index 0.
  - Otherwise set load_err=1, drop the word and go to ERROR, whether or not word_last is set.
- WRITE:
  - Lasts exactly 4 cycles with word_ready=0 and im_we=1.
  - Cycle k (k=0..3): im_addr=base+k and im_wdata=latched word[8k+7:8k].
  - After k=3: base+=4 and word_count+=1. Go to DONE if the latched last flag is set, else to IDLE.
- Throughput: a word accepted at edge t is written on cycles t+1..t+4. word_ready is high again in cycle t+5, so the loader takes at most 1 word per 5 cycles.
- DONE:
  - cpu_run=1 on the first cycle in DONE. word_ready=0 and im_we=0.
  - word_valid is ignored.
- ERROR:
  - cpu_run=0, load_err=1, word_ready=0.
  - The loader stays here until reload or reset.
- reload=1 in DONE or ERROR:
  - Next cycle: IDLE, cpu_run=0, load_err=0, base=0, word_count=0.
  - Memory contents are not cleared.
- reload in IDLE or WRITE is ignored; a word in progress always completes.
- im_addr and im_wdata hold their last values when im_we=0.
- word_count does not wrap: with MEM_BYTES a multiple of 4, overflow reaches ERROR first.
- Exactly MEM_BYTES/4 words with word_last on the final word is legal: the loader ends in DONE with no error.
- word_last arriving without word_valid has no effect.
- Reset asserted mid-WRITE aborts the partial word. Bytes already written stay in memory, but word_count is cleared.

Test Plan:
- Load 0x8C010004, 0x20020005, 0xAC020008, with last on the third word → bytes 0x04,0x00,0x01,0x8C at addresses 0..3; all 12 bytes correct; word_count=3; cpu_run=1 at cycle 15 after the first accept; cpu_run=0 before that.
- word_valid held high continuously → handshakes exactly 5 cycles apart; word_ready=0 during each 4-cycle WRITE.
- MEM_BYTES=16, stream 5 words with last on the fifth → 4 words written; fifth word dropped; load_err=1, cpu_run=0, state ERROR; no im_we pulse for the fifth word.
- MEM_BYTES=16, exactly 4 words with last on the fourth → DONE, load_err=0, word_count=4, last write to im_addr=15.
- Loader in DONE, pulse reload, then load 1 word 0xDEADBEEF with last → cpu_run drops for the reload; address 0..3 rewritten to EF,BE,AD,DE; word_count=1; cpu_run rises again.
- Assert rst_n=0 during byte index 2 of word 2 → all outputs 0 immediately, without waiting for a clock edge; after release the next word is written to address 0.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time instruction loader. Accepts a stream of 32-bit
//            instruction words and writes each one little-endian, one byte
//            per cycle, into the byte-wide instruction memory starting at
//            address 0. The core is held off (cpu_run=0) until the word
//            flagged as last has been fully written.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_BYTES  instruction memory size in bytes (multiple of 4)
//   ADDR_W     width of im_addr and word_count
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   word_valid  in   upstream word valid
//   word_data   in   instruction word, [7:0] goes to the lowest address
//   word_last   in   marks the final word of the program
//   word_ready  out  loader can accept a word this cycle
//   reload      in   pulse, restarts loading from address 0 (DONE/ERROR only)
//   im_we       out  instruction memory byte write enable
//   im_addr     out  byte address of the current write
//   im_wdata    out  byte being written
//   cpu_run     out  core released
//   load_err    out  sticky: program did not fit in MEM_BYTES
//   word_count  out  words written since last reset or reload
// ============================================================================
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [7:0]        im_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // One extra bit so base+4 cannot wrap before being compared to the size.
  localparam logic [ADDR_W:0] c_mem_bytes = (ADDR_W+1)'(MEM_BYTES);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_idx;
  logic [23:0]       r_hi;    // upper three bytes still to be written
  logic              r_last;

  logic              w_fits;
  logic              w_hs;

  assign w_fits = (({1'b0, r_base} + (ADDR_W+1)'(4)) <= c_mem_bytes);
  assign w_hs   = word_valid & word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_idx      <= 2'd0;
      r_hi       <= 24'd0;
      r_last     <= 1'b0;
      word_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= 8'd0;
      cpu_run    <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          im_we <= 1'b0;
          if (w_hs) begin
            word_ready <= 1'b0;
            if (w_fits) begin
              // Byte 0 goes out on the cycle right after the handshake.
              r_state  <= WRITE;
              r_idx    <= 2'd0;
              r_hi     <= word_data[31:8];
              r_last   <= word_last;
              im_we    <= 1'b1;
              im_addr  <= r_base;
              im_wdata <= word_data[7:0];
            end else begin
              r_state  <= ERROR;
              load_err <= 1'b1;
            end
          end else begin
            word_ready <= 1'b1;
          end
        end

        WRITE: begin
          if (r_idx != 2'd3) begin
            r_idx    <= r_idx + 2'd1;
            im_addr  <= im_addr + ADDR_W'(1);
            im_wdata <= r_hi[7:0];
            r_hi     <= {8'h00, r_hi[23:8]};
          end else begin
            // Last byte just went out: commit the word.
            im_we      <= 1'b0;
            r_base     <= r_base + ADDR_W'(4);
            word_count <= word_count + ADDR_W'(1);
            if (r_last) begin
              r_state <= DONE;
              cpu_run <= 1'b1;
            end else begin
              r_state    <= IDLE;
              word_ready <= 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          im_we      <= 1'b0;
          word_ready <= 1'b0;
          if (reload) begin
            r_state    <= IDLE;
            word_ready <= 1'b1;
            cpu_run    <= 1'b0;
            load_err   <= 1'b0;
            r_base     <= '0;
            word_count <= '0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
